// File: rtl/ram_ring_ctrl_if.sv
// Handshake and RAM-address bundle between the ring-buffer controller and its
// UART/RAM neighbours. The master drives the events; the slave is the controller.
interface ram_ring_ctrl_if #(
    parameter int AW = 13
) ();
    logic          auto_mode;
    logic          rx_done;
    logic          key_flag;
    logic          key_state;
    logic          tx_done;
    logic [AW-1:0] addra;
    logic          wea;
    logic [AW-1:0] addrb;
    logic          send_en;
    logic [AW:0]   count;
    logic          overflow;
    logic          led;

    modport master (
        output auto_mode, rx_done, key_flag, key_state, tx_done,
        input  addra, wea, addrb, send_en, count, overflow, led
    );

    modport slave (
        input  auto_mode, rx_done, key_flag, key_state, tx_done,
        output addra, wea, addrb, send_en, count, overflow, led
    );
endinterface

// File: rtl/ram_ring_ctrl.sv
// Ring-buffer controller sharing a dual-port byte RAM between UART receive
// (write side) and UART transmit (read side, send_en/tx_done handshake).
module ram_ring_ctrl #(
    parameter int AW     = 13,
    parameter int RD_LAT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    ram_ring_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT_TX} state_t;

    localparam logic [AW:0] FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [2:0]  LAT_INIT = 3'(RD_LAT - 1);

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, addra_q, addrb_q;
    logic [AW-1:0] addra_d;
    logic [AW:0]   count_q, count_d, occ;
    logic          wea_q, overflow_q, send_en_q, drain_q;
    logic [2:0]    lat_q;
    logic          full, accept, rd_done, press;

    // Occupancy includes the byte being written this cycle, so a pending
    // write both blocks an over-fill and lets the reader start one cycle early.
    assign occ     = count_q + {{AW{1'b0}}, wea_q};
    assign full    = (occ == FULL);
    assign accept  = bus.rx_done && !full;
    assign rd_done = (state_q == WAIT_TX) && bus.tx_done;
    assign press   = bus.key_flag && !bus.key_state;

    always_comb begin
        count_d = count_q;
        case ({wea_q, rd_done})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // While a write is in progress wr_ptr_q still points at it.
    assign addra_d = wr_ptr_q + AW'(wea_q);

    always_ff @(posedge clk) begin
        if (reset_n) begin
            wea_q      <= 1'b0;
            addra_q    <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wea_q   <= accept;
            count_q <= count_d;
            if (accept)
                addra_q <= addra_d;
            if (wea_q)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (bus.rx_done && full)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            send_en_q <= 1'b0;
            drain_q   <= 1'b0;
            rd_ptr_q  <= '0;
            addrb_q   <= '0;
        end else begin
            send_en_q <= 1'b0;
            addrb_q   <= rd_ptr_q;
            case (state_q)
                IDLE: begin
                    if (press && !bus.auto_mode)
                        drain_q <= 1'b1;
                    else if (occ == '0)
                        drain_q <= 1'b0;
                    if (occ != '0 && (bus.auto_mode || drain_q)) begin
                        state_q <= FETCH;
                        lat_q   <= LAT_INIT;
                    end
                end
                FETCH: begin
                    if (lat_q == '0) begin
                        state_q   <= SEND;
                        send_en_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                SEND: state_q <= WAIT_TX;
                WAIT_TX: begin
                    // The byte is released only once the transmitter is done.
                    if (bus.tx_done) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addra    = addra_q;
    assign bus.wea      = wea_q;
    assign bus.addrb    = addrb_q;
    assign bus.send_en  = send_en_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.led      = drain_q || (state_q != IDLE);
endmodule

// File: tb/tb_ram_ring_ctrl.sv
// Bench for ram_ring_ctrl: directed scenarios on a full-size instance and a
// small AW=3 instance, then randomized traffic against a queue-based model.
module tb_ram_ring_ctrl;
    localparam int DEPTH3 = 8;
    localparam int LAT3   = 3;

    logic clk = 1'b0;
    logic rst13 = 1'b1;
    logic rst3  = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_ring_ctrl_if #(.AW(13)) if13 ();
    ram_ring_ctrl_if #(.AW(3))  if3 ();

    ram_ring_ctrl #(.AW(13), .RD_LAT(2))    dut13 (.clk(clk), .reset_n(rst13), .bus(if13));
    ram_ring_ctrl #(.AW(3),  .RD_LAT(LAT3)) dut3  (.clk(clk), .reset_n(rst3),  .bus(if3));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit sel);
        if (sel) rst3 = 1'b1; else rst13 = 1'b1;
        tick();
        tick();
        if (sel) rst3 = 1'b0; else rst13 = 1'b0;
    endtask

    task automatic check_reset13(input string tag);
        check_val({tag, " addra"},    if13.addra,    0);
        check_val({tag, " addrb"},    if13.addrb,    0);
        check_val({tag, " wea"},      if13.wea,      0);
        check_val({tag, " send_en"},  if13.send_en,  0);
        check_val({tag, " count"},    if13.count,    0);
        check_val({tag, " overflow"}, if13.overflow, 0);
        check_val({tag, " led"},      if13.led,      0);
    endtask

    task automatic wait_send(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((sel ? if3.send_en : if13.send_en) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic answer_tx(input bit sel);
        tick();
        if (sel) if3.tx_done = 1'b1; else if13.tx_done = 1'b1;
        tick();
        if (sel) if3.tx_done = 1'b0; else if13.tx_done = 1'b0;
    endtask

    task automatic press_key(input bit sel);
        if (sel) begin if3.key_flag = 1'b1; if3.key_state = 1'b0; end
        else     begin if13.key_flag = 1'b1; if13.key_state = 1'b0; end
        tick();
        if (sel) if3.key_flag = 1'b0; else if13.key_flag = 1'b0;
    endtask

    // Randomized auto-mode traffic on the AW=3 instance. A byte received in
    // cycle N is sent at max(prev tx_done + 2, N + 2) + read latency.
    task automatic run_random(input int ncyc);
        int q_rx[$];
        int occ = 0, cnt = 0, wr = 0, rd = 0, last_done = -100;
        int waitc = 0, exp_addra = 0, e = 0, sends = 0, rate = 0;
        bit wea_exp = 0, ovf = 0, busy = 0, just = 0, acc = 0, freed = 0;
        bit rxb = 0, txb = 0, se_exp = 0;
        for (int k = 0; k < ncyc; k++) begin
            check_val("R wea",      if3.wea,      wea_exp);
            check_val("R addra",    if3.addra,    exp_addra);
            check_val("R count",    if3.count,    cnt);
            check_val("R overflow", if3.overflow, ovf);
            se_exp = 1'b0;
            if (q_rx.size() > 0 && !busy) begin
                e = ((last_done > q_rx[0]) ? last_done : q_rx[0]) + 2 + LAT3;
                se_exp = (cyc == e);
            end
            check_val("R send_en", if3.send_en, se_exp);
            just = 1'b0;
            if (if3.send_en === 1'b1) begin
                check_val("R addrb", if3.addrb, rd);
                busy  = 1'b1;
                just  = 1'b1;
                waitc = $urandom_range(0, 4);
                if (q_rx.size() > 0) void'(q_rx.pop_front());
                sends++;
            end
            rate = (k < ncyc / 2) ? 8 : 45;
            rxb  = ($urandom_range(0, 99) < rate);
            txb  = 1'b0;
            if (busy && !just) begin
                if (waitc == 0) txb = 1'b1; else waitc--;
            end else if (!busy && $urandom_range(0, 7) == 0) begin
                txb = 1'b1;
            end
            if3.rx_done = rxb;
            if3.tx_done = txb;
            acc   = rxb && (occ != DEPTH3);
            if (rxb && !acc) ovf = 1'b1;
            freed = txb && busy && !just;
            cnt   = cnt + int'(wea_exp) - int'(freed);
            occ   = occ + int'(acc) - int'(freed);
            if (freed) begin
                busy      = 1'b0;
                last_done = cyc;
                rd        = (rd + 1) % DEPTH3;
            end
            wea_exp = acc;
            if (acc) begin
                exp_addra = wr;
                wr        = (wr + 1) % DEPTH3;
                q_rx.push_back(cyc);
            end
            tick();
        end
        if3.rx_done = 1'b0;
        if3.tx_done = 1'b0;
        check_val("R enough sends", (sends > 20) ? 1 : 0, 1);
    endtask

    initial begin
        bit ok;
        bit seen;
        int n, wea_cnt;
        if13.auto_mode = 1'b1; if13.rx_done = 1'b0; if13.key_flag = 1'b0;
        if13.key_state = 1'b1; if13.tx_done = 1'b0;
        if3.auto_mode  = 1'b0; if3.rx_done  = 1'b0; if3.key_flag  = 1'b0;
        if3.key_state  = 1'b1; if3.tx_done  = 1'b0;

        // Auto mode: single byte
        do_reset(0);
        do_reset(1);
        check_reset13("A reset");
        tick();
        if13.rx_done = 1'b1;
        tick();
        if13.rx_done = 1'b0;
        check_val("A wea N+1", if13.wea, 1);
        check_val("A addra N+1", if13.addra, 0);
        tick();
        check_val("A count N+2", if13.count, 1);
        check_val("A send_en N+2", if13.send_en, 0);
        tick();
        check_val("A send_en N+3", if13.send_en, 0);
        tick();
        check_val("A send_en N+4", if13.send_en, 1);
        check_val("A addrb N+4", if13.addrb, 0);
        tick();
        check_val("A send_en single", if13.send_en, 0);
        tick();
        if13.tx_done = 1'b1;
        tick();
        if13.tx_done = 1'b0;
        check_val("A count after tx", if13.count, 0);
        check_val("A led after tx", if13.led, 0);
        tick();
        check_val("A addrb after tx", if13.addrb, 1);

        // Manual mode: three bytes drained by a key press
        do_reset(0);
        if13.auto_mode = 1'b0;
        if13.rx_done = 1'b1;
        tick(); tick(); tick();
        if13.rx_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= if13.send_en;
        end
        check_val("B no send before key", seen, 0);
        check_val("B count", if13.count, 3);
        check_val("B led idle", if13.led, 0);
        press_key(0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            wait_send(0, ok);
            if (!ok) break;
            check_val("B addrb", if13.addrb, i);
            check_val("B led busy", if13.led, 1);
            answer_tx(0);
            n++;
        end
        check_val("B sends", n, 3);
        tick(); tick(); tick();
        check_val("B led done", if13.led, 0);
        check_val("B count done", if13.count, 0);

        // AW=3 manual: overflow on the 9th byte, drain exactly 8
        if3.auto_mode = 1'b0;
        do_reset(1);
        wea_cnt = 0;
        if3.rx_done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            wea_cnt += int'(if3.wea);
            if (i == 8) begin
                check_val("C 9th no wea", if3.wea, 0);
                if3.rx_done = 1'b0;
            end
        end
        tick(); tick();
        wea_cnt += int'(if3.wea);
        check_val("C wea pulses", wea_cnt, 8);
        check_val("C count full", if3.count, 8);
        check_val("C overflow", if3.overflow, 1);
        press_key(1);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            wait_send(1, ok);
            if (!ok) break;
            check_val("C addrb", if3.addrb, i % 8);
            answer_tx(1);
            n++;
        end
        check_val("C drained", n, 8);
        check_val("C count empty", if3.count, 0);
        check_val("C led", if3.led, 0);
        check_val("C overflow sticky", if3.overflow, 1);

        // Write and read completion in the same cycle
        do_reset(0);
        if13.auto_mode = 1'b0;
        if13.rx_done = 1'b1;
        tick(); tick();
        if13.rx_done = 1'b0;
        tick(); tick(); tick();
        check_val("D count 2", if13.count, 2);
        if13.auto_mode = 1'b1;
        wait_send(0, ok);
        check_val("D send seen", ok, 1);
        check_val("D addrb", if13.addrb, 0);
        tick();
        if13.rx_done = 1'b1;
        tick();
        if13.rx_done = 1'b0;
        check_val("D wea", if13.wea, 1);
        check_val("D addra", if13.addra, 2);
        if13.tx_done = 1'b1;
        tick();
        if13.tx_done = 1'b0;
        check_val("D count kept", if13.count, 2);
        tick();
        check_val("D addrb advanced", if13.addrb, 1);
        check_val("D count still", if13.count, 2);

        // Reset during WAIT_TX, then a stray tx_done
        wait_send(0, ok);
        check_val("E send seen", ok, 1);
        tick();
        rst13 = 1'b1;
        tick();
        rst13 = 1'b0;
        check_reset13("E reset");
        if13.tx_done = 1'b1;
        tick();
        if13.tx_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= if13.send_en;
        end
        check_val("E no send", seen, 0);
        check_val("E count", if13.count, 0);
        check_val("E addrb", if13.addrb, 0);
        check_val("E led", if13.led, 0);

        // Randomized auto-mode traffic with wrap and overflow
        if3.auto_mode = 1'b1;
        do_reset(1);
        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/ram_ring_ctrl.md
# ram_ring_ctrl

Ring-buffer controller that sequences the shared dual-port byte RAM between the UART receive path and the UART transmit path. Received bytes are written at a wrapping write pointer; stored bytes are read back at a wrapping read pointer and handed to the byte transmitter one at a time under a `send_en`/`tx_done` handshake. Playback is either continuous (auto mode) or triggered by a debounced key press (manual mode, drains until empty).

## Interface

Parameters:

- `AW`, 13, RAM address width; depth is 2**AW bytes.
- `RD_LAT`, 2, RAM read latency in clk cycles from an `addrb` change to a valid `q`; legal range 1..4.

Ports:

- `clk` in 1: single clock for all logic.
- `reset_n` in 1: reset, synchronous and active-high. Asserting it (1) resets on the next clk edge.
- `auto_mode` in 1: 1 = stream whenever the buffer is non-empty; 0 = stream only after a key press.
- `rx_done` in 1: one-cycle pulse; the received byte is stable on the RAM data input.
- `key_flag` in 1: one-cycle debounced key event.
- `key_state` in 1: debounced key level; a press is `key_flag && !key_state`.
- `tx_done` in 1: one-cycle pulse; the transmitter has finished the current byte.
- `addra` out AW: RAM write address.
- `wea` out 1: RAM write enable.
- `addrb` out AW: RAM read address.
- `send_en` out 1: one-cycle start pulse to the transmitter.
- `count` out AW+1: number of stored, unsent bytes.
- `overflow` out 1: sticky; a byte was dropped because the buffer was full.
- `led` out 1: busy indicator.

## Operation

- Pointers: `wr_ptr` and `rd_ptr` are AW bits wide and wrap modulo 2**AW.
- `count` is AW+1 bits.
  - Full when `count == 2**AW`.
  - Empty when `count == 0`.
- Write side, on `rx_done`:
  - Not full: in the next cycle drive `wea=1` and `addra=wr_ptr`. At the end of that cycle, increment `wr_ptr` and `count`.
  - Full: no write; set `overflow=1`. Only reset clears `overflow`.
- `addra` holds its last value when `wea=0`.
- `addrb` always equals `rd_ptr`; it is registered and updates the cycle after `rd_ptr` changes.
- `drain` flag:
  - Set by a key press while in IDLE with `auto_mode=0`.
  - Cleared in IDLE when `count==0`.
  - Key presses in any other state are ignored.
- Read FSM, states IDLE, FETCH, SEND, WAIT_TX:
  - IDLE → FETCH when `count!=0` and (`auto_mode` or `drain`).
  - FETCH: wait exactly RD_LAT cycles, then go to SEND.
  - SEND: `send_en=1` for exactly this one cycle, then go to WAIT_TX.
  - WAIT_TX: on `tx_done`, increment `rd_ptr`, decrement `count`, go to IDLE.
- `tx_done` outside WAIT_TX is ignored.
- If a write and a read completion land in the same cycle, `count` is unchanged and both pointers advance.
- Changing `auto_mode` mid-transfer does not abort the transfer; it takes effect at the next IDLE decision.
- `led = drain || (state != IDLE)`.
- A byte is freed only after `tx_done`. A full buffer therefore stays full while its oldest byte is in flight.

## Timing

- Reset values:
  - `addra=0`, `addrb=0`, `wea=0`, `send_en=0`, `count=0`, `overflow=0`, `led=0`.
  - State IDLE, `drain=0`, both pointers 0.
- Reset mid-operation discards all buffered data. A `tx_done` arriving after reset is ignored.
- `rx_done` in cycle N:
  - `wea=1` in cycle N+1.
  - `count` is updated and visible in N+2.
- Auto mode, empty buffer, `rx_done` at cycle N:
  - FETCH starts at N+2.
  - `send_en` at N+2+RD_LAT, which is N+4 at the default latency.
- Back-to-back bytes: after `tx_done` at cycle T, the next `send_en` comes no earlier than T+2+RD_LAT.
- `rx_done` may arrive every cycle; each non-full pulse produces exactly one write.
- Read-after-write hazard: the first fetch of an address begins at least one cycle after its write edge, so there is no same-address collision.

## Test plan

- Auto mode, `rx_done` with byte 0x5A at cycle N:
  - `wea=1`, `addra=0` at N+1.
  - `send_en` single pulse at N+4 with `addrb=0`.
  - After `tx_done`: `count=0`, `addrb=1`, `led=0`.
- Manual mode, write 0x11, 0x22, 0x33:
  - No `send_en` before the key press; `count=3`.
  - After the press: three `send_en` pulses, each answered by `tx_done`, with `addrb` 0, 1, 2 in order.
  - `led=1` until the buffer is empty, then 0.
- `AW=3`, manual mode, write 9 bytes:
  - 8 stored, `count=8`, `overflow=1`.
  - The 9th `rx_done` produces no `wea`.
  - Drain sends exactly 8 bytes.
- `AW=3`, auto mode, 20 bytes spaced for transmission:
  - `addra` and `addrb` wrap 7→0.
  - 20 `send_en` pulses, in order, with no loss; `overflow=0`.
- Buffer holding 2 bytes, auto mode: `rx_done` write cycle coincides with `tx_done` in WAIT_TX → `count` stays 2 and both pointers advance.
- Assert `reset_n` for 1 cycle during WAIT_TX, then pulse `tx_done`:
  - All outputs return to their reset values.
  - No `send_en` and no `count` change afterwards.
